// File: rtl/srt2_control_unit.sv
// srt2_control_unit
// Moore sequencer for the SRT-2 radix-2 divider datapath. It walks one
// division per start pulse (load, normalise, SRT iterations, correction,
// quotient assembly, denormalise, output) and drives the 14-bit control
// word c[13:0]. c, busy and done decode only from registered state and
// registered flags, so there is no input-to-output combinational path.
//
// Handshake: start is sampled only in IDLE. busy is high from LOAD_Q through
// DONE. done is a one-cycle pulse in DONE, where busy is also high. If start
// is still high in the IDLE cycle after DONE, the next division begins.
module srt2_control_unit #(
    parameter logic [2:0] LAST_CNT        = 3'd7,
    parameter bit         SKIP_ZERO_DIGIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic        cnt1,
    input  logic [2:0]  cnt2,
    input  logic        m7,
    input  logic [2:0]  ctrl_bits,
    output logic [13:0] c,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_Q = 4'd1,
        S_LOAD_M = 4'd2,
        S_CHK_M  = 4'd3,
        S_NORM   = 4'd4,
        S_SEL    = 4'd5,
        S_SHIFT  = 4'd6,
        S_ADDSUB = 4'd7,
        S_COUNT  = 4'd8,
        S_CORR   = 4'd9,
        S_QFIX   = 4'd10,
        S_DENORM = 4'd11,
        S_OUT_Q  = 4'd12,
        S_OUT_A  = 4'd13,
        S_DONE   = 4'd14
    } state_t;

    // Quotient digit selected for the current iteration.
    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_POS  = 2'd1,
        OP_NEG  = 2'd2
    } op_t;

    // Control word bit strobes.
    localparam logic [13:0] C_LOAD_AQ = 14'h0001; // load A/Q/Q*/CNT2
    localparam logic [13:0] C_LOAD_M  = 14'h0002; // load M, count leading zeros
    localparam logic [13:0] C_NORM    = 14'h0004; // normalise, latch ctrl_bits, CNT1++
    localparam logic [13:0] C_SHIFT   = 14'h0008; // shift strobe
    localparam logic [13:0] C_DIG_P   = 14'h0010; // digit +1
    localparam logic [13:0] C_DIG_N   = 14'h0020; // digit -1 / subtract
    localparam logic [13:0] C_FIN     = 14'h0040; // finish-phase qualifier
    localparam logic [13:0] C_ASM_Q   = 14'h0080; // assemble qualifier
    localparam logic [13:0] C_CNT2    = 14'h0100; // CNT2++
    localparam logic [13:0] C_ADD_M   = 14'h0200; // add-M strobe
    localparam logic [13:0] C_ASM     = 14'h0400; // assemble strobe
    localparam logic [13:0] C_DENORM  = 14'h0800; // denormalise, CNT1--
    localparam logic [13:0] C_OUT1    = 14'h1000; // drive outbus1
    localparam logic [13:0] C_OUT2    = 14'h2000; // drive outbus2

    state_t state_q, state_d;
    op_t    op_q, op_d;
    logic   neg_q, neg_d;
    logic   shift_q, shift_d;

    // State and flag registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            op_q    <= OP_ZERO;
            neg_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            shift_q <= shift_d;
        end
    end

    // Next-state, flag capture and Moore output decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        shift_d = shift_q;
        c       = 14'h0000;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD_Q;
                end
            end
            S_LOAD_Q: begin
                c       = C_LOAD_AQ;
                state_d = S_LOAD_M;
            end
            S_LOAD_M: begin
                c       = C_LOAD_M;
                state_d = S_CHK_M;
            end
            S_CHK_M: begin
                // A divisor with its MSB already set needs no normalise step.
                state_d = m7 ? S_SEL : S_NORM;
            end
            S_NORM: begin
                c       = C_NORM;
                state_d = S_SEL;
            end
            S_SEL: begin
                if (ctrl_bits == 3'b000 || ctrl_bits == 3'b111) begin
                    op_d = OP_ZERO;
                end else if (!ctrl_bits[2]) begin
                    op_d = OP_POS;
                end else begin
                    op_d = OP_NEG;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                c = C_SHIFT;
                if (op_q == OP_POS) begin
                    c = c | C_DIG_P;
                end else if (op_q == OP_NEG) begin
                    c = c | C_DIG_N;
                end
                if (op_q == OP_ZERO && SKIP_ZERO_DIGIT) begin
                    state_d = S_COUNT;
                end else begin
                    state_d = S_ADDSUB;
                end
            end
            S_ADDSUB: begin
                if (op_q == OP_POS) begin
                    c = C_DIG_N;
                end else if (op_q == OP_NEG) begin
                    c = C_ADD_M;
                end
                state_d = S_COUNT;
            end
            S_COUNT: begin
                // Exit test precedes the increment, so cnt2 never wraps.
                if (cnt2 == LAST_CNT) begin
                    neg_d   = ctrl_bits[2];
                    state_d = S_CORR;
                end else begin
                    c       = C_CNT2;
                    state_d = S_SEL;
                end
            end
            S_CORR: begin
                // Negative remainder: restore A += M and bump Q*.
                if (neg_q) begin
                    c = C_FIN | C_ADD_M;
                end
                shift_d = cnt1;
                state_d = S_QFIX;
            end
            S_QFIX: begin
                c       = C_FIN | C_ASM_Q | C_ASM;
                state_d = S_DENORM;
            end
            S_DENORM: begin
                if (shift_q) begin
                    c = C_DENORM;
                end
                state_d = S_OUT_Q;
            end
            S_OUT_Q: begin
                c       = C_OUT1;
                state_d = S_OUT_A;
            end
            S_OUT_A: begin
                c       = C_OUT2;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_srt2_control_unit.sv
// tb_srt2_control_unit
// Directed bench for the SRT-2 sequencer. A tiny cnt2 model stands in for
// the datapath iteration counter (cleared by c0, incremented by c8). Each
// division is captured cycle by cycle into trace[], with cycle 1 being the
// LOAD_Q cycle, and then checked against hand-computed values.
module tb_srt2_control_unit;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic        cnt1;
    logic [2:0]  cnt2;
    logic        m7;
    logic [2:0]  ctrl_bits;
    logic [13:0] c;
    logic        busy;
    logic        done;

    int n_chk;
    int n_bad;

    logic [13:0] trace [0:63];
    int          done_cyc;
    logic        busy_done;

    srt2_control_unit dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .m7        (m7),
        .ctrl_bits (ctrl_bits),
        .c         (c),
        .busy      (busy),
        .done      (done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath iteration counter stand-in
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt2 <= 3'd0;
        end else if (c[0]) begin
            cnt2 <= 3'd0;
        end else if (c[8]) begin
            cnt2 <= cnt2 + 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_eq(input logic [13:0] v);
        int n = 0;
        for (int i = 1; i <= done_cyc; i++) begin
            if (trace[i] == v) n++;
        end
        return n;
    endfunction

    function automatic int cnt_bit(input int b);
        int n = 0;
        for (int i = 1; i <= done_cyc; i++) begin
            if (trace[i][b]) n++;
        end
        return n;
    endfunction

    // Run one division; start pulses for the sampling edge, then is driven
    // high again at cycle pulse_at and/or from cycle hold_from onward.
    task automatic run_div(input logic m7_v, input logic [2:0] cb, input logic cnt1_v,
                           input int pulse_at, input int hold_from);
        m7        = m7_v;
        ctrl_bits = cb;
        cnt1      = cnt1_v;
        for (int i = 0; i < 64; i++) trace[i] = 14'h0;
        done_cyc  = 0;
        busy_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 60 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            trace[cyc] = c;
            if (done) begin
                done_cyc  = cyc;
                busy_done = busy;
            end
            start = (cyc == pulse_at) || (hold_from > 0 && cyc >= hold_from);
        end
        chk("done_seen", 32'(done_cyc != 0), 32'd1);
    endtask

    initial begin
        int n_out;
        int n_busy;
        int pairs;
        int waited;

        n_chk     = 0;
        n_bad     = 0;
        rst_b     = 1'b0;
        start     = 1'b0;
        cnt1      = 1'b0;
        m7        = 1'b0;
        ctrl_bits = 3'b000;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_c", 32'(c), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // reset asserted in LOAD_M aborts at once, no output strobes follow
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_loadq", 32'(c), 32'h0001);
        @(negedge clk);
        chk("abort_loadm", 32'(c), 32'h0002);
        rst_b = 1'b0;
        #1;
        chk("abort_c", 32'(c), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_b  = 1'b1;
        n_out  = 0;
        n_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c[12] || c[13]) n_out++;
            if (busy) n_busy++;
        end
        chk("abort_no_out", 32'(n_out), 32'd0);
        chk("abort_no_busy", 32'(n_busy), 32'd0);

        // m7=0, all-zero digits: LOAD_Q,LOAD_M,CHK_M,NORM + 8*3 + 6 = 34
        run_div(1'b0, 3'b000, 1'b0, 0, 0);
        chk("z_loadq", 32'(trace[1]), 32'h0001);
        chk("z_norm_pos", 32'(trace[4]), 32'h0004);
        chk("z_norm_cnt", 32'(cnt_eq(14'h0004)), 32'd1);
        chk("z_shift_cnt", 32'(cnt_eq(14'h0008)), 32'd8);
        chk("z_no_sub", 32'(cnt_bit(5)), 32'd0);
        chk("z_no_addm", 32'(cnt_bit(9)), 32'd0);
        chk("z_c8_cnt", 32'(cnt_bit(8)), 32'd7);
        chk("z_qfix", 32'(trace[30]), 32'h04C0);
        chk("z_out_q", 32'(trace[32]), 32'h1000);
        chk("z_out_a", 32'(trace[33]), 32'h2000);
        chk("z_done_cyc", 32'(done_cyc), 32'd34);
        chk("z_busy_done", 32'(busy_done), 32'd1);
        @(negedge clk);
        chk("z_after_done", 32'(done), 32'd0);
        chk("z_after_busy", 32'(busy), 32'd0);

        // m7=1, positive digits: 3 + 8*4 + 6 = 41
        run_div(1'b1, 3'b010, 1'b0, 0, 0);
        chk("p_sel", 32'(trace[4]), 32'h0000);
        chk("p_shift", 32'(trace[5]), 32'h0018);
        chk("p_addsub", 32'(trace[6]), 32'h0020);
        chk("p_count", 32'(trace[7]), 32'h0100);
        chk("p_norm_cnt", 32'(cnt_eq(14'h0004)), 32'd0);
        pairs = 0;
        for (int i = 1; i < done_cyc; i++) begin
            if (trace[i] == 14'h0018 && trace[i+1] == 14'h0020) pairs++;
        end
        chk("p_pairs", 32'(pairs), 32'd8);
        chk("p_c8_cnt", 32'(cnt_bit(8)), 32'd7);
        chk("p_corr", 32'(trace[36]), 32'h0000);
        chk("p_done_cyc", 32'(done_cyc), 32'd41);

        // m7=1, negative digits and negative remainder at exit
        run_div(1'b1, 3'b101, 1'b0, 0, 0);
        chk("n_shift", 32'(trace[5]), 32'h0028);
        chk("n_addsub", 32'(trace[6]), 32'h0200);
        chk("n_shift_cnt", 32'(cnt_eq(14'h0028)), 32'd8);
        chk("n_addm_cnt", 32'(cnt_eq(14'h0200)), 32'd8);
        chk("n_corr", 32'(trace[36]), 32'h0240);
        chk("n_qfix", 32'(trace[37]), 32'h04C0);
        chk("n_denorm", 32'(trace[38]), 32'h0000);
        chk("n_done_cyc", 32'(done_cyc), 32'd41);

        // cnt1=1 at exit -> denormalise; m7=1 zero digits: 3 + 24 + 6 = 33
        run_div(1'b1, 3'b111, 1'b1, 0, 0);
        chk("d1_denorm", 32'(trace[30]), 32'h0800);
        chk("d1_denorm_cnt", 32'(cnt_bit(11)), 32'd1);
        chk("d1_out_q", 32'(trace[31]), 32'h1000);
        chk("d1_out_a", 32'(trace[32]), 32'h2000);
        chk("d1_done_cyc", 32'(done_cyc), 32'd33);
        run_div(1'b1, 3'b111, 1'b0, 0, 0);
        chk("d0_denorm", 32'(trace[30]), 32'h0000);
        chk("d0_denorm_cnt", 32'(cnt_bit(11)), 32'd0);
        chk("d0_out_q", 32'(trace[31]), 32'h1000);
        chk("d0_out_a", 32'(trace[32]), 32'h2000);
        chk("d0_done_cyc", 32'(done_cyc), 32'd33);

        // mid-division start pulse ignored, then start held through DONE
        run_div(1'b1, 3'b000, 1'b0, 10, 20);
        chk("h_loadq_cnt", 32'(cnt_eq(14'h0001)), 32'd1);
        chk("h_done_cyc", 32'(done_cyc), 32'd33);
        @(negedge clk);
        chk("h_idle_c", 32'(c), 32'h0000);
        chk("h_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("h_restart_c", 32'(c), 32'h0001);
        chk("h_restart_busy", 32'(busy), 32'd1);
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("h_restart_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
